// File: rtl/ifetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch slice.
package ifetch_unit_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    // Instruction-queue sizing, also used by the decoder's stall logic.
    localparam int unsigned QUEUE_LOG2  = 4;
    localparam int unsigned QUEUE_DEPTH = 1 << QUEUE_LOG2;

    // Fetch FSM encodings
    localparam logic [1:0] FETCH    = 2'd0;
    localparam logic [1:0] WAIT_MEM = 2'd1;
    localparam logic [1:0] DISCARD  = 2'd2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Bus bundle between the fetch unit and its ICache, memory controller and consumer.
interface ifetch_unit_if;
    import ifetch_unit_pkg::*;

    logic                  rdy;
    logic [DATA_WIDTH-1:0] ic_addr;
    logic                  ic_hit;
    logic [DATA_WIDTH-1:0] ic_inst;
    logic                  ic_wr_en;
    logic [DATA_WIDTH-1:0] ic_wr_addr;
    logic [DATA_WIDTH-1:0] ic_wr_inst;
    logic                  mem_req;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_done;
    logic [DATA_WIDTH-1:0] mem_inst;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_inst;
    logic [DATA_WIDTH-1:0] out_pc;
    logic                  deq_en;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;

    // Fetch unit side
    modport master (
        input  rdy, ic_hit, ic_inst, mem_done, mem_inst, deq_en, redirect, redirect_pc,
        output ic_addr, ic_wr_en, ic_wr_addr, ic_wr_inst, mem_req, mem_addr,
        output out_valid, out_inst, out_pc
    );

    // Environment side (ICache, memory controller, consumer)
    modport slave (
        output rdy, ic_hit, ic_inst, mem_done, mem_inst, deq_en, redirect, redirect_pc,
        input  ic_addr, ic_wr_en, ic_wr_addr, ic_wr_inst, mem_req, mem_addr,
        input  out_valid, out_inst, out_pc
    );

endinterface

// File: rtl/ifetch_unit_inst_fifo.sv
// Circular {pc, inst} queue with clear; push is ignored when full, pop when empty.
module ifetch_unit_inst_fifo
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned LOG2 = QUEUE_LOG2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t push_entry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned DEPTH = 1 << LOG2;

    fetch_entry_t    mem_q [DEPTH];
    logic [LOG2-1:0] head_q, tail_q;
    logic [LOG2:0]   count_q;
    logic            do_push, do_pop;

    assign full    = (count_q == (LOG2+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign head    = mem_q[head_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (en) begin
            if (clear) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (do_push) tail_q <= tail_q + 1'b1;
                if (do_pop)  head_q <= head_q + 1'b1;
                if (do_push && !do_pop)      count_q <= count_q + 1'b1;
                else if (!do_push && do_pop) count_q <= count_q - 1'b1;
            end
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (en && do_push) mem_q[tail_q] <= push_entry;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC, ICache lookup, miss handling and redirect flush.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned         QUEUE_LOG2 = ifetch_unit_pkg::QUEUE_LOG2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0
) (
    input logic           clk,
    input logic           rst,
    ifetch_unit_if.master bus
);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic                  mem_req_q, mem_req_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  ic_wr_en_q, ic_wr_en_d;
    logic [DATA_WIDTH-1:0] ic_wr_addr_q, ic_wr_addr_d;
    logic [DATA_WIDTH-1:0] ic_wr_inst_q, ic_wr_inst_d;

    logic         q_push, q_clear, q_full, q_empty;
    fetch_entry_t q_head;

    // Next-state: lookup/miss handling, with redirect overriding everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        miss_addr_d  = miss_addr_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        ic_wr_en_d   = 1'b0;
        ic_wr_addr_d = ic_wr_addr_q;
        ic_wr_inst_d = ic_wr_inst_q;
        q_push       = 1'b0;
        q_clear      = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (!bus.redirect && !q_full) begin
                    if (bus.ic_hit) begin
                        q_push = 1'b1;
                        pc_d   = pc_q + 32'd4;
                    end else begin
                        miss_addr_d = pc_q;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = pc_q;
                        state_d     = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM, DISCARD: begin
                // The fill is valid for miss_addr even if a redirect intervened.
                if (bus.mem_done) begin
                    mem_req_d    = 1'b0;
                    ic_wr_en_d   = 1'b1;
                    ic_wr_addr_d = miss_addr_q;
                    ic_wr_inst_d = bus.mem_inst;
                    state_d      = FETCH;
                end else if (bus.redirect) begin
                    state_d = DISCARD;
                end
            end
            default: state_d = FETCH;
        endcase

        if (bus.redirect) begin
            q_clear = 1'b1;
            pc_d    = bus.redirect_pc;
        end
    end

    // State registers; rdy low freezes everything except reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            miss_addr_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            ic_wr_en_q   <= 1'b0;
            ic_wr_addr_q <= '0;
            ic_wr_inst_q <= '0;
        end else if (bus.rdy) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            miss_addr_q  <= miss_addr_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            ic_wr_en_q   <= ic_wr_en_d;
            ic_wr_addr_q <= ic_wr_addr_d;
            ic_wr_inst_q <= ic_wr_inst_d;
        end
    end

    ifetch_unit_inst_fifo #(
        .LOG2 (QUEUE_LOG2)
    ) u_inst_fifo (
        .clk        (clk),
        .rst        (rst),
        .en         (bus.rdy),
        .push       (q_push),
        .pop        (bus.deq_en),
        .clear      (q_clear),
        .push_entry ('{pc: pc_q, inst: bus.ic_inst}),
        .full       (q_full),
        .empty      (q_empty),
        .head       (q_head)
    );

    assign bus.ic_addr    = pc_q;
    assign bus.ic_wr_en   = ic_wr_en_q;
    assign bus.ic_wr_addr = ic_wr_addr_q;
    assign bus.ic_wr_inst = ic_wr_inst_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.out_valid  = !q_empty;
    assign bus.out_pc     = q_head.pc;
    assign bus.out_inst   = q_head.inst;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with an ICache model and a dequeue scoreboard.
module tb_ifetch_unit;
    import ifetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;

    ifetch_unit_if bus ();

    ifetch_unit #(
        .QUEUE_LOG2 (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ICache model: word array below 0x1000 plus same-cycle forwarding of the fill write.
    bit          cv [1024];
    logic [31:0] cd [1024];

    always_comb begin
        bus.ic_hit  = 1'b0;
        bus.ic_inst = 32'h0;
        if (bus.ic_wr_en && bus.ic_wr_addr == bus.ic_addr) begin
            bus.ic_hit  = 1'b1;
            bus.ic_inst = bus.ic_wr_inst;
        end else if (bus.ic_addr[31:12] == 20'h0 && cv[bus.ic_addr[11:2]]) begin
            bus.ic_hit  = 1'b1;
            bus.ic_inst = cd[bus.ic_addr[11:2]];
        end
    end

    logic [63:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    logic req_seen = 1'b0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] base, input int words);
        for (int i = 0; i < words; i++) begin
            logic [31:0] a;
            a = base + 32'(i * 4);
            cv[a[11:2]] = 1'b1;
            cd[a[11:2]] = inst_of(a);
        end
    endtask

    task automatic push_range(input logic [31:0] base, input int words);
        for (int i = 0; i < words; i++) begin
            logic [31:0] a;
            a = base + 32'(i * 4);
            exp_q.push_back({a, inst_of(a)});
        end
    endtask

    // One clock: mid-cycle monitor (cache fill, scoreboard pop), then settle after the edge.
    task automatic tick();
        logic [63:0] e;
        @(negedge clk);
        if (bus.ic_wr_en) begin
            cv[bus.ic_wr_addr[11:2]] = 1'b1;
            cd[bus.ic_wr_addr[11:2]] = bus.ic_wr_inst;
            wr_cnt++;
        end
        if (bus.mem_req) req_seen = 1'b1;
        if (bus.rdy && !rst && !bus.redirect && bus.deq_en && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("deq_pc", bus.out_pc, e[63:32]);
                chk("deq_inst", bus.out_inst, e[31:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        preload(32'h0, 32);      // 0x00..0x7C; 0x80 left cold
        preload(32'h200, 16);
        preload(32'h300, 16);
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.deq_en = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.mem_done = 1'b0;
        bus.mem_inst = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_ic_addr", bus.ic_addr, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_ic_wr_en", 32'(bus.ic_wr_en), 32'd0);
        chk("rst_ic_wr_addr", bus.ic_wr_addr, 32'h0);

        // Warm hit stream, one instruction per cycle
        rst = 1'b0;
        bus.deq_en = 1'b1;
        req_seen = 1'b0;
        push_range(32'h0, 16);
        repeat (17) tick();
        chk("warm_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("warm_no_mem_req", 32'(req_seen), 32'd0);

        // Full queue: 16 entries from 0x0, pc parks at 0x40
        bus.deq_en = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0;
        tick();
        bus.redirect = 1'b0;
        exp_q.delete();
        repeat (20) tick();
        chk("full_pc", bus.ic_addr, 32'h40);
        chk("full_head_pc", bus.out_pc, 32'h0);
        push_range(32'h0, 17);
        bus.deq_en = 1'b1;
        tick();
        bus.deq_en = 1'b0;
        chk("full_deq_no_enq", bus.ic_addr, 32'h40);
        tick();
        chk("full_one_enq", bus.ic_addr, 32'h44);
        tick();
        tick();
        chk("full_stall_again", bus.ic_addr, 32'h44);

        // Redirect mid-stream with a same-cycle dequeue
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0;
        tick();
        bus.redirect = 1'b0;
        exp_q.delete();
        repeat (5) tick();
        chk("mid_five_queued", 32'(bus.out_valid), 32'd1);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h200;
        bus.deq_en = 1'b1;
        tick();
        bus.redirect = 1'b0;
        bus.deq_en = 1'b0;
        chk("mid_flushed", 32'(bus.out_valid), 32'd0);
        chk("mid_new_pc", bus.ic_addr, 32'h200);
        tick();
        chk("mid_valid", 32'(bus.out_valid), 32'd1);
        chk("mid_head_pc", bus.out_pc, 32'h200);
        chk("mid_head_inst", bus.out_inst, inst_of(32'h200));

        // Redirect while a miss at 0x80 is outstanding
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h78;
        tick();
        bus.redirect = 1'b0;
        repeat (3) tick();
        chk("dis_mem_req", 32'(bus.mem_req), 32'd1);
        chk("dis_mem_addr", bus.mem_addr, 32'h80);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h300;
        tick();
        bus.redirect = 1'b0;
        chk("dis_flushed", 32'(bus.out_valid), 32'd0);
        chk("dis_pc", bus.ic_addr, 32'h300);
        chk("dis_req_held", 32'(bus.mem_req), 32'd1);
        tick();
        tick();
        chk("dis_no_enq", 32'(bus.out_valid), 32'd0);
        chk("dis_req_held2", 32'(bus.mem_req), 32'd1);
        bus.mem_done = 1'b1;
        bus.mem_inst = 32'h1111_1111;
        tick();
        bus.mem_done = 1'b0;
        chk("dis_wr_en", 32'(bus.ic_wr_en), 32'd1);
        chk("dis_wr_addr", bus.ic_wr_addr, 32'h80);
        chk("dis_wr_inst", bus.ic_wr_inst, 32'h1111_1111);
        chk("dis_req_drop", 32'(bus.mem_req), 32'd0);
        tick();
        chk("dis_resume_valid", 32'(bus.out_valid), 32'd1);
        chk("dis_resume_pc", bus.out_pc, 32'h300);
        chk("dis_wr_pulse", 32'(bus.ic_wr_en), 32'd0);

        // Cold miss at 0x100, memory answers after 5 cycles
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h100;
        bus.deq_en = 1'b1;
        exp_q.delete();
        exp_q.push_back({32'h100, 32'h00A0_0093});
        tick();
        bus.redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("cold_mem_req", 32'(bus.mem_req), 32'd1);
            chk("cold_mem_addr", bus.mem_addr, 32'h100);
        end
        bus.mem_done = 1'b1;
        bus.mem_inst = 32'h00A0_0093;
        tick();
        bus.mem_done = 1'b0;
        chk("cold_wr_en", 32'(bus.ic_wr_en), 32'd1);
        chk("cold_wr_addr", bus.ic_wr_addr, 32'h100);
        chk("cold_wr_inst", bus.ic_wr_inst, 32'h00A0_0093);
        chk("cold_req_drop", 32'(bus.mem_req), 32'd0);
        tick();
        chk("cold_out_valid", 32'(bus.out_valid), 32'd1);
        chk("cold_out_pc", bus.out_pc, 32'h100);
        chk("cold_out_inst", bus.out_inst, 32'h00A0_0093);
        tick();
        bus.deq_en = 1'b0;
        chk("cold_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("miss2_mem_req", 32'(bus.mem_req), 32'd1);
        chk("miss2_mem_addr", bus.mem_addr, 32'h104);

        // rdy low in WAIT_MEM freezes everything
        bus.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_mem_req", 32'(bus.mem_req), 32'd1);
            chk("frz_mem_addr", bus.mem_addr, 32'h104);
            chk("frz_pc", bus.ic_addr, 32'h104);
            chk("frz_out_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.rdy = 1'b1;

        // Reset asserted in WAIT_MEM
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst2_pc", bus.ic_addr, 32'h0);
        chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2_wr_en", 32'(bus.ic_wr_en), 32'd0);
        chk("wr_pulse_count", 32'(wr_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
